// File: rtl/pwm_multichan_pkg.sv
// Shared defaults, address map constant and per-channel config record for pwm_multichan.
package pwm_multichan_pkg;

    localparam int unsigned NCH_DEF     = 4;
    localparam int unsigned CW_DEF      = 8;
    localparam int unsigned DT_DEF      = 2;
    localparam int unsigned CW_MAX      = 16;
    localparam int unsigned ADDR_PERIOD = NCH_DEF;

    // Duty fields are sized for the widest supported counter; narrower builds zero-extend.
    typedef struct packed {
        logic [CW_MAX-1:0] duty_sh;
        logic [CW_MAX-1:0] duty_act;
    } chan_cfg_t;

endpackage

// File: rtl/pwm_multichan_if.sv
// Configuration write port: valid/ready handshake plus error pulse.
interface pwm_multichan_if #(
    parameter int unsigned NCH = pwm_multichan_pkg::NCH_DEF,
    parameter int unsigned CW  = pwm_multichan_pkg::CW_DEF
);
    localparam int unsigned AW = $clog2(NCH + 1);

    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW-1:0] cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          cfg_err;

    modport master (
        output cfg_valid, cfg_addr, cfg_data,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/pwm_multichan_deadtime.sv
// Per-channel dead-time insertion: each output rises only after its source has been
// high for DT consecutive samples and drops in the cycle its source drops.
module pwm_deadtime #(
    parameter int unsigned DT = pwm_multichan_pkg::DT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic en,
    output logic pwm,
    output logic pwm_n
);

    localparam int unsigned    DW   = (DT > 0) ? $clog2(DT + 1) : 1;
    localparam logic [DW-1:0]  DT_V = DW'(DT);

    logic [DW-1:0] run_hi;
    logic [DW-1:0] run_lo;
    logic          src_lo_c;

    // Low-side source is the raw compare inverted, only while running.
    assign src_lo_c = en && !raw;

    // Saturating run-length counters and registered gated outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_hi <= '0;
            run_lo <= '0;
            pwm    <= 1'b0;
            pwm_n  <= 1'b0;
        end else begin
            pwm    <= raw && (run_hi == DT_V);
            pwm_n  <= src_lo_c && (run_lo == DT_V);
            run_hi <= raw ? ((run_hi == DT_V) ? run_hi : run_hi + DW'(1)) : '0;
            run_lo <= src_lo_c ? ((run_lo == DT_V) ? run_lo : run_lo + DW'(1)) : '0;
        end
    end

endmodule

// File: rtl/pwm_multichan.sv
// Multi-channel PWM with shadowed duty/period registers, period-boundary reload,
// complementary outputs with dead-time, and a period-start sync pulse.
module pwm_multichan
    import pwm_multichan_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned CW  = CW_DEF,
    parameter int unsigned DT  = DT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    pwm_multichan_if.slave        cfg,
    output logic [NCH-1:0]        pwm_o,
    output logic [NCH-1:0]        pwm_n_o,
    output logic                  sync_o
);

    localparam int unsigned   AW       = $clog2(NCH + 1);
    localparam logic [AW-1:0] ADDR_PER = AW'(NCH);

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     per_sh;
    logic [CW-1:0]     per_act;
    logic [CW-1:0]     per_sh_nxt;
    chan_cfg_t         chan        [NCH];
    logic [CW_MAX-1:0] duty_sh_nxt [NCH];
    logic [NCH-1:0]    raw_c;
    logic              reload_c;
    logic              ready_c;
    logic              wr_c;
    logic              err_c;
    logic              err_q;

    // Reload happens on the last count of a running period; writes are blocked then.
    assign reload_c      = en && (cnt == per_act);
    assign ready_c       = rst_n && !reload_c;
    assign wr_c          = cfg.cfg_valid && ready_c;
    assign err_c         = wr_c && (cfg.cfg_addr > ADDR_PER);
    assign cfg.cfg_ready = ready_c;
    assign cfg.cfg_err   = err_q;

    // Shadow values after applying this cycle's accepted write.
    always_comb begin
        per_sh_nxt = per_sh;
        for (int i = 0; i < NCH; i++) begin
            duty_sh_nxt[i] = chan[i].duty_sh;
        end
        if (wr_c) begin
            if (cfg.cfg_addr == ADDR_PER) begin
                per_sh_nxt = cfg.cfg_data;
            end
            for (int i = 0; i < NCH; i++) begin
                if (cfg.cfg_addr == AW'(i)) begin
                    duty_sh_nxt[i] = CW_MAX'(cfg.cfg_data);
                end
            end
        end
    end

    // Raw compare; a duty above the period keeps the channel high since cnt never reaches it.
    always_comb begin
        raw_c = '0;
        for (int i = 0; i < NCH; i++) begin
            raw_c[i] = en && (CW_MAX'(cnt) < chan[i].duty_act);
        end
    end

    // Shadow/active registers: actives track shadows while stopped, reload at period end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_sh  <= '1;
            per_act <= '1;
            for (int i = 0; i < NCH; i++) begin
                chan[i] <= '{duty_sh: '0, duty_act: '0};
            end
        end else begin
            per_sh <= per_sh_nxt;
            if (!en || reload_c) begin
                per_act <= per_sh_nxt;
            end
            for (int i = 0; i < NCH; i++) begin
                chan[i].duty_sh <= duty_sh_nxt[i];
                if (!en || reload_c) begin
                    chan[i].duty_act <= duty_sh_nxt[i];
                end
            end
        end
    end

    // Period counter, parked at zero while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt <= '0;
        end else if (cnt == per_act) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Registered sync and config error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_o <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sync_o <= en && (cnt == '0);
            err_q  <= err_c;
        end
    end

    // One dead-time stage per channel.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pwm_deadtime #(.DT(DT)) u_dt (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_c[g]),
            .en    (en),
            .pwm   (pwm_o[g]),
            .pwm_n (pwm_n_o[g])
        );
    end

endmodule

// File: tb/tb_pwm_multichan.sv
// Randomized scoreboard bench for pwm_multichan against a waveform-level reference model.
module tb_pwm_multichan;
    import pwm_multichan_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned DT  = 2;
    localparam int unsigned AW  = $clog2(NCH + 1);

    typedef struct packed {
        logic [NCH-1:0] pwm;
        logic [NCH-1:0] pwm_n;
        logic           sync;
        logic           err;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [NCH-1:0] pwm_o;
    logic [NCH-1:0] pwm_n_o;
    logic           sync_o;
    logic           en_cur;

    pwm_multichan_if #(.NCH(NCH), .CW(CW)) cfg_if ();

    pwm_multichan #(.NCH(NCH), .CW(CW), .DT(DT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .cfg     (cfg_if),
        .pwm_o   (pwm_o),
        .pwm_n_o (pwm_n_o),
        .sync_o  (sync_o)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    // Reference model: register file plus position within the current period and
    // a window of the last DT+1 raw compare samples since the outputs were enabled.
    int             m_per_sh;
    int             m_per_act;
    int             m_pos;
    int             m_duty_sh  [NCH];
    int             m_duty_act [NCH];
    logic [NCH-1:0] m_hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic v,
                              input int a, input int d, output logic acc);
        exp_t           x;
        logic           rdy;
        logic [NCH-1:0] raw;
        x   = '0;
        raw = '0;
        acc = 1'b0;
        if (!r) begin
            rdy       = 1'b0;
            m_per_sh  = 255;
            m_per_act = 255;
            m_pos     = 0;
            for (int i = 0; i < NCH; i++) begin
                m_duty_sh[i]  = 0;
                m_duty_act[i] = 0;
            end
            m_hist.delete();
        end else begin
            rdy = !(e && (m_pos == m_per_act));
            acc = v && rdy;
            for (int i = 0; i < NCH; i++) begin
                raw[i] = e && (m_pos < m_duty_act[i]);
            end
            x.sync = e && (m_pos == 0);
            x.err  = acc && (a > NCH);
            if (e) begin
                m_hist.push_back(raw);
                if (m_hist.size() > DT + 1) void'(m_hist.pop_front());
            end else begin
                m_hist.delete();
            end
            if (m_hist.size() == DT + 1) begin
                for (int i = 0; i < NCH; i++) begin
                    x.pwm[i]   = 1'b1;
                    x.pwm_n[i] = 1'b1;
                    foreach (m_hist[k]) begin
                        if (m_hist[k][i]) x.pwm_n[i] = 1'b0;
                        else              x.pwm[i]   = 1'b0;
                    end
                end
            end
            if (acc) begin
                if (a == NCH)     m_per_sh     = d;
                else if (a < NCH) m_duty_sh[a] = d;
            end
            if (!e || (m_pos == m_per_act)) begin
                m_per_act = m_per_sh;
                for (int i = 0; i < NCH; i++) m_duty_act[i] = m_duty_sh[i];
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(rdy));
        exp_q.push_back(x);
    endtask

    task automatic cyc(input logic r, input logic e, input logic v,
                       input int a, input int d, output logic acc);
        @(negedge clk);
        rst_n            = r;
        en               = e;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_addr  = AW'(a);
        cfg_if.cfg_data  = CW'(d);
        #1;
        model_step(r, e, v, a, d, acc);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) cyc(1'b1, en_cur, 1'b0, 0, 0, acc);
    endtask

    task automatic wr(input int a, input int d);
        logic acc;
        int   k;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 400) begin
            cyc(1'b1, en_cur, 1'b1, a, d, acc);
            k++;
        end
        n_checks++;
        if (!acc) begin
            n_errors++;
            $display("FAIL wr_accept: addr %0d never accepted within 400 cycles", a);
        end
    endtask

    // Monitor: one expected output record per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs{pwm,pwm_n,sync,err}",
                      32'({pwm_o, pwm_n_o, sync_o, cfg_if.cfg_err}), 32'(e));
                check("no_overlap", 32'(pwm_o & pwm_n_o), 32'(0));
            end
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        int   a;
        int   d;
        rst_n            = 1'b0;
        en               = 1'b0;
        en_cur           = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_addr  = '0;
        cfg_if.cfg_data  = '0;

        // Reset, then free run at the default 256-cycle period.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 0, 0, acc);
        en_cur = 1'b1;
        idle(600);

        // Mid-period period/duty update, effective after the next reload.
        wr(ADDR_PERIOD, 9);
        wr(0, 5);
        idle(300);

        // Zero duty, duty above period, pulse shorter than dead-time.
        wr(1, 0);
        wr(2, 10);
        wr(3, 1);
        idle(40);

        // Invalid addresses.
        wr(7, 33);
        wr(5, 1);
        wr(6, 2);
        idle(20);

        // Continuously asserted valid with changing targets.
        for (int k = 0; k < 80; k++) begin
            a = $urandom_range(0, NCH);
            d = (a == NCH) ? $urandom_range(3, 12) : $urandom_range(0, 12);
            cyc(1'b1, 1'b1, 1'b1, a, d, acc);
        end
        idle(30);

        // Random enables and writes, including zero period.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) < 3) en_cur = !en_cur;
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom_range(0, 7);
                d = (a == NCH) ? $urandom_range(0, 20) : $urandom_range(0, 22);
                cyc(1'b1, en_cur, 1'b1, a, d, acc);
            end else begin
                cyc(1'b1, en_cur, 1'b0, 0, 0, acc);
            end
        end

        // Mid-period reset with a write in flight, then defaults return.
        en_cur = 1'b0;
        idle(2);
        wr(ADDR_PERIOD, 9);
        wr(0, 6);
        en_cur = 1'b1;
        idle(14);
        cyc(1'b0, 1'b1, 1'b1, 0, 7, acc);
        idle(300);

        @(posedge clk);
        #3;
        check("queue_drain", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_multichan.md
PWM_MULTICHAN -- requirements
Module: pwm_multichan

Interface
REQ-001 Parameter NCH, 4, number of PWM channels (1..16) SHALL be supported.
REQ-002 Parameter CW, 8, counter/duty/period width in bits (4..16) SHALL be supported.
REQ-003 Parameter DT, 2, dead-time in clk cycles (0..15) SHALL be supported.
REQ-004 Port clk  in  1  single clock; all logic rising-edge.
REQ-005 Port rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port en  in  1  run enable; low freezes counter at 0 and forces outputs low.
REQ-007 Port cfg_valid  in  1  config write request.
REQ-008 Port cfg_ready  out  1  config write accept.
REQ-009 Port cfg_addr  in  $clog2(NCH+1)  0..NCH-1 = channel duty; NCH = period.
REQ-010 Port cfg_data  in  CW  duty or period value.
REQ-011 Port cfg_err  out  1  one-cycle pulse on accepted write to invalid address.
REQ-012 Port pwm_o  out  NCH  high-side PWM outputs.
REQ-013 Port pwm_n_o  out  NCH  complementary low-side outputs.
REQ-014 Port sync_o  out  1  one-cycle pulse when counter is 0 (period start).

Function
REQ-015 Counter cnt SHALL count 0..per_act, then wrap to 0; per_act = 0 SHALL keep cnt at 0 (every cycle is a period start).
REQ-016 Each channel and the period SHALL have a shadow register (written via cfg) and an active register (used by compare).
REQ-017 Active registers SHALL load from shadows in the cycle cnt == per_act (reload cycle) while en = 1; new values take effect from cnt = 0.
REQ-018 Write accepted when cfg_valid && cfg_ready; cfg_ready SHALL be 0 in the reload cycle and 1 otherwise (except during reset).
REQ-019 Shadows SHALL accept writes while en = 0; on en rising, active registers SHALL load from shadows before cnt leaves 0.
REQ-020 cfg_addr > NCH SHALL write nothing and pulse cfg_err the cycle after acceptance.
REQ-021 Raw compare per channel: raw = (cnt < duty_act); duty_act = 0 -> raw always 0; duty_act > per_act -> raw always 1.
REQ-022 raw SHALL be registered: pwm_o/pwm_n_o reflect cnt with exactly 1 cycle latency plus dead-time.
REQ-023 Dead-time: pwm_o rises DT cycles after raw rises; pwm_n_o rises DT cycles after raw falls; each falls in the cycle its own source falls.
REQ-024 pwm_o and pwm_n_o of one channel SHALL never be 1 simultaneously.
REQ-025 Pulse (high or low phase) shorter than or equal to DT cycles SHALL suppress the corresponding output entirely for that phase.
REQ-026 DT = 0 SHALL give pwm_n_o == ~pwm_o while en = 1.
REQ-027 sync_o SHALL be 1 for one cycle whenever cnt == 0 and en = 1, aligned with pwm outputs (same 1-cycle latency).
REQ-028 en falling SHALL force pwm_o, pwm_n_o, sync_o to 0 the next cycle, reset cnt to 0 and clear dead-time counters; shadows retained.

Reset
REQ-029 rst_n = 0 at a clk edge SHALL set cnt = 0, all duties (shadow/active) = 0, period (shadow/active) = 2^CW-1.
REQ-030 During and after reset: pwm_o = 0, pwm_n_o = 0, sync_o = 0, cfg_err = 0, cfg_ready = 0 while rst_n = 0.
REQ-031 Reset mid-period SHALL abort the period immediately; an in-flight cfg write in the reset cycle SHALL be discarded.

Structure
REQ-032 Package pwm_multichan_pkg SHALL hold default NCH/CW/DT, the period address constant (ADDR_PERIOD = NCH), and the channel config struct (duty shadow, duty active).
REQ-033 Sub-module pwm_deadtime (one raw input, pwm/pwm_n outputs, DT counter) SHALL be instantiated NCH times via generate.
REQ-034 Counter, reload logic and cfg decode SHALL live in pwm_multichan top.

Verification (NCH=4, CW=8, DT=2)
REQ-035 Reset, en=1, no writes -> period 256 cycles, pwm_o = 0, pwm_n_o high from 3rd cycle after en, sync_o every 256 cycles.
REQ-036 Write period=9, ch0 duty=5 mid-period -> takes effect after next reload; ch0 pwm_o high 3 cycles (5-2), pwm_n_o high 3 cycles (5-2), period 10.
REQ-037 Duty=0 -> pwm_o never 1; duty=10 with period=9 -> pwm_o constant 1 after DT, pwm_n_o 0.
REQ-038 period=9, duty=1 -> pwm_o never asserts (pulse <= DT); cfg_addr=7 write -> cfg_err pulse, no register changed.
REQ-039 cfg_valid held continuously -> cfg_ready low exactly in reload cycles; all writes land; assert never both outputs high.
REQ-040 rst_n low mid-period with en=1 -> next cycle all outputs 0, period returns to 255, duties 0.
